// File: rtl/ram_write_arbiter.sv
// ram_write_arbiter
//   Round-robin arbiter that shares the RAM's single stream write port between
//   NUM_REQ byte-write requesters. One requester owns the port per grant. Each
//   accepted beat is packed into {8'h00, addr, 8'h00, data} and held on the
//   master stream until the RAM takes it. A grant ends on the requester's
//   last beat, after MAX_BURST beats, or when the owner drops valid.
//
// Ports
//   aclk, aresetn      clock, synchronous active-low reset
//   req_valid/ready    per-requester handshake (ready is combinational, one-hot or 0)
//   req_addr/req_data  packed bytes, requester i at [8i+7:8i]
//   req_last           last beat of the requester's burst
//   m_axis_*           master stream toward the RAM slave port
//   grant              registered one-hot owner, 0 when idle
//   busy               high while a beat is being offered
//   beat_count         beats accepted by the RAM, wraps at 16 bits
module ram_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic [15:0]          beat_count
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t [NUM_REQ-1:0] beats;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign beats[gi] = {req_addr[8*gi +: 8], req_data[8*gi +: 8], req_last[gi]};
    end

    state_t          state, state_nxt;
    logic [IDXW-1:0] last_grant;
    logic [IDXW-1:0] owner;
    logic [7:0]      burst_cnt;
    logic            last_flag;

    logic            win_found;
    logic [IDXW-1:0] win_idx;
    logic            accept;
    logic            cont;
    logic            take;
    logic [IDXW-1:0] take_idx;

    assign accept = m_axis_tvalid & m_axis_tready;
    assign busy   = (state == SEND);

    // The owner may chain another beat only once the current one is accepted,
    // so a captured beat is never overwritten.
    assign cont = accept & ~last_flag & (burst_cnt < 8'(MAX_BURST)) & req_valid[owner];

    // Rotating priority: scan upward from the slot after the previous owner.
    always_comb begin
        int              idx;
        logic [IDXW-1:0] idx_l;
        win_found = 1'b0;
        win_idx   = last_grant;
        idx       = 0;
        idx_l     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_l = IDXW'(idx);
            if (!win_found && req_valid[idx_l]) begin
                win_found = 1'b1;
                win_idx   = idx_l;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        take      = 1'b0;
        take_idx  = owner;
        if (aresetn) begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        req_ready[win_idx] = 1'b1;
                        take               = 1'b1;
                        take_idx           = win_idx;
                        state_nxt          = SEND;
                    end
                end
                SEND: begin
                    if (cont) begin
                        req_ready[owner] = 1'b1;
                        take             = 1'b1;
                    end else if (accept) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= IDLE;
            last_grant    <= IDXW'(NUM_REQ - 1);
            owner         <= '0;
            burst_cnt     <= '0;
            last_flag     <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            grant         <= '0;
            beat_count    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) beat_count <= beat_count + 16'd1;
            if (take) begin
                m_axis_tdata  <= {8'h00, beats[take_idx].addr, 8'h00, beats[take_idx].data};
                last_flag     <= beats[take_idx].last;
                m_axis_tvalid <= 1'b1;
                owner         <= take_idx;
                grant         <= {{(NUM_REQ-1){1'b0}}, 1'b1} << take_idx;
                // A fresh grant restarts the burst count.
                burst_cnt     <= (state == IDLE) ? 8'd1 : burst_cnt + 8'd1;
            end else if (accept) begin
                m_axis_tvalid <= 1'b0;
                grant         <= '0;
                last_grant    <= owner;
            end
        end
    end

endmodule

// File: tb/tb_ram_write_arbiter.sv
module tb_ram_write_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;

    logic           aclk = 1'b0;
    logic           aresetn;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_addr;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [31:0]    m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tready;
    logic [N-1:0]   grant;
    logic           busy;
    logic [15:0]    beat_count;

    ram_write_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .grant(grant), .busy(busy), .beat_count(beat_count)
    );

    initial forever #5 aclk = ~aclk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        logic       l;
    } src_t;

    typedef struct {
        logic [31:0]  word;
        logic [N-1:0] gnt;
    } exp_t;

    src_t src_q [N][$];
    exp_t exp_q [$];
    logic [7:0] mem [256];

    int   n_vec;
    int   n_err;
    logic hold;
    logic ram_mode;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_src(input int r, input logic [7:0] a, input logic [7:0] d, input logic l);
        src_t s;
        s.a = a; s.d = d; s.l = l;
        src_q[r].push_back(s);
    endtask

    task automatic push_exp(input logic [31:0] w, input logic [N-1:0] g);
        exp_t e;
        e.word = w; e.gnt = g;
        exp_q.push_back(e);
    endtask

    function automatic bit srcs_empty();
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic apply_src();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0) begin
                req_valid[i]       = 1'b1;
                req_addr[8*i +: 8] = src_q[i][0].a;
                req_data[8*i +: 8] = src_q[i][0].d;
                req_last[i]        = src_q[i][0].l;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    // Requesters pop a beat after each handshake; the RAM side drops tready
    // for one cycle after every write when ram_mode is set.
    task automatic driver();
        logic [N-1:0] hs;
        logic         acc;
        apply_src();
        m_axis_tready = 1'b1;
        forever begin
            @(negedge aclk);
            hs  = req_valid & req_ready;
            acc = aresetn & m_axis_tvalid & m_axis_tready;
            @(posedge aclk);
            #1;
            for (int i = 0; i < N; i++) if (hs[i]) void'(src_q[i].pop_front());
            apply_src();
            m_axis_tready = hold ? 1'b0 : (ram_mode ? ~acc : 1'b1);
        end
    endtask

    task automatic monitor();
        logic        pend;
        logic [31:0] prev;
        exp_t        e;
        pend = 1'b0;
        prev = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                pend = 1'b0;
                check("rst_ready", {28'd0, req_ready}, 32'd0);
            end else begin
                if (pend) begin
                    check("hold_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
                    check("hold_tdata", m_axis_tdata, prev);
                end
                check("ready_onehot", {31'd0, $countones(req_ready) <= 1}, 32'd1);
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_beat: got %h, want none", m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_word", m_axis_tdata, e.word);
                        check("beat_grant", {28'd0, grant}, {28'd0, e.gnt});
                    end
                    mem[m_axis_tdata[23:16]] = m_axis_tdata[7:0];
                end
                pend = m_axis_tvalid & ~m_axis_tready;
                prev = m_axis_tdata;
            end
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #2;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        step();
        while (!(exp_q.size() == 0 && srcs_empty() && !busy) && t < 300) begin
            step();
            t++;
        end
        if (t >= 300) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle: got %0d pending beats, want 0", exp_q.size());
        end
    endtask

    logic [3:0] fair_seq [12];
    logic [15:0] saved;

    initial begin
        int t;
        n_vec = 0; n_err = 0;
        hold = 1'b0; ram_mode = 1'b0;
        aresetn = 1'b0;
        req_valid = '0; req_addr = '0; req_data = '0; req_last = '0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        fair_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000,
                     4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000};

        // fairness traffic is already requesting during reset
        push_src(0, 8'h20, 8'hA0, 1'b1); push_src(0, 8'h24, 8'hA4, 1'b1);
        push_src(1, 8'h21, 8'hA1, 1'b1); push_src(1, 8'h25, 8'hA5, 1'b1);
        push_src(2, 8'h22, 8'hA2, 1'b1);
        push_src(3, 8'h23, 8'hA3, 1'b1);
        push_exp(32'h002000A0, 4'b0001);
        push_exp(32'h002100A1, 4'b0010);
        push_exp(32'h002200A2, 4'b0100);
        push_exp(32'h002300A3, 4'b1000);
        push_exp(32'h002400A4, 4'b0001);
        push_exp(32'h002500A5, 4'b0010);

        fork
            driver();
            monitor();
        join_none

        // reset held 3 cycles with every requester valid
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_req_ready", {28'd0, req_ready}, 32'd0);
            check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
            check("rst_grant", {28'd0, grant}, 32'd0);
            check("rst_beat_count", {16'd0, beat_count}, 32'd0);
        end
        check("rst_tdata", m_axis_tdata, 32'd0);
        aresetn = 1'b1;

        // round robin from r0, one idle cycle between grants
        for (int c = 0; c < 12; c++) begin
            step();
            check("fair_grant", {28'd0, grant}, {28'd0, fair_seq[c]});
        end
        wait_idle();

        // single beat latency
        push_src(1, 8'h10, 8'hAB, 1'b1);
        push_exp(32'h001000AB, 4'b0010);
        step();
        check("single_ready", {28'd0, req_ready}, 32'h2);
        check("single_tvalid0", {31'd0, m_axis_tvalid}, 32'd0);
        step();
        check("single_tvalid1", {31'd0, m_axis_tvalid}, 32'd1);
        check("single_tdata", m_axis_tdata, 32'h001000AB);
        check("single_grant", {28'd0, grant}, 32'h2);
        check("single_ready_off", {28'd0, req_ready}, 32'd0);
        step();
        check("single_idle_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("single_idle_grant", {28'd0, grant}, 32'd0);
        check("single_count", {16'd0, beat_count}, 32'd7);
        wait_idle();

        // burst cap: r2 gets 4, then r3, then r2's remaining 2
        for (int k = 0; k < 6; k++) push_src(2, 8'h30 + 8'(k), 8'hB0 + 8'(k), 1'b0);
        push_src(3, 8'h40, 8'hC0, 1'b1);
        push_exp(32'h003000B0, 4'b0100);
        push_exp(32'h003100B1, 4'b0100);
        push_exp(32'h003200B2, 4'b0100);
        push_exp(32'h003300B3, 4'b0100);
        push_exp(32'h004000C0, 4'b1000);
        push_exp(32'h003400B4, 4'b0100);
        push_exp(32'h003500B5, 4'b0100);
        wait_idle();
        check("burst_count", {16'd0, beat_count}, 32'd14);

        // RAM-style tready toggling plus a 5-cycle stall mid-burst
        ram_mode = 1'b1;
        push_src(0, 8'h50, 8'hD0, 1'b0);
        push_src(0, 8'h51, 8'hD1, 1'b0);
        push_src(0, 8'h52, 8'hD2, 1'b0);
        push_src(0, 8'h53, 8'hD3, 1'b1);
        push_exp(32'h005000D0, 4'b0001);
        push_exp(32'h005100D1, 4'b0001);
        push_exp(32'h005200D2, 4'b0001);
        push_exp(32'h005300D3, 4'b0001);
        t = 0;
        while (beat_count != 16'd16 && t < 100) begin step(); t++; end
        check("bp_reach_2", {16'd0, beat_count}, 32'd16);
        hold = 1'b1;
        repeat (5) step();
        check("bp_stall_count", {16'd0, beat_count}, 32'd16);
        hold = 1'b0;
        wait_idle();
        ram_mode = 1'b0;
        check("mem_50", {24'd0, mem[8'h50]}, 32'hD0);
        check("mem_51", {24'd0, mem[8'h51]}, 32'hD1);
        check("mem_52", {24'd0, mem[8'h52]}, 32'hD2);
        check("mem_53", {24'd0, mem[8'h53]}, 32'hD3);
        check("bp_count", {16'd0, beat_count}, 32'd18);

        // reset while a beat is stalled: it must vanish uncounted
        hold = 1'b1;
        push_src(3, 8'h60, 8'hE0, 1'b1);
        t = 0;
        step();
        while (!m_axis_tvalid && t < 50) begin step(); t++; end
        check("mid_tvalid_up", {31'd0, m_axis_tvalid}, 32'd1);
        saved = beat_count;
        aresetn = 1'b0;
        push_src(0, 8'h61, 8'hE1, 1'b1);
        push_src(3, 8'h62, 8'hE2, 1'b1);
        step();
        check("mid_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("mid_rst_grant", {28'd0, grant}, 32'd0);
        check("mid_rst_count", {16'd0, beat_count}, 32'd0);
        check("mid_saved", {16'd0, saved}, 32'd18);
        hold = 1'b0;
        step();
        push_exp(32'h006100E1, 4'b0001);
        push_exp(32'h006200E2, 4'b1000);
        aresetn = 1'b1;
        wait_idle();
        check("final_count", {16'd0, beat_count}, 32'd2);
        check("mem_60_unwritten", {24'd0, mem[8'h60]}, 32'h00);
        check("mem_61", {24'd0, mem[8'h61]}, 32'hE1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
